// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath control FSM.
// Build option: DATAPATH_CTRL_ILLEGAL_TRAP_EN (see datapath_ctrl_decode / datapath_ctrl_fsm).
package datapath_ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG,
        S_WR_IMM,
        S_HALT,
        S_ERR
    } state_t;

    // opcode = instr[15:13]
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // op = instr[12:11]
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // One-hot register-file index selects
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // Writeback source
    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    // Registered control word driven toward the datapath
    typedef struct packed {
        logic       w;
        logic       done;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       err;
        logic [2:0] nsel;
        logic       vsel;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{w: 1'b1, default: '0};

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Instruction decode: picks the state that follows DECODE and classifies
// the instruction for EXEC (zero-A operand, compare-only).
// Build option: DATAPATH_CTRL_ILLEGAL_TRAP_EN routes illegal opcodes to ERR
// instead of retiring them as a NOP.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output state_t      next_st,
    output logic        asel_cls,
    output logic        is_cmp,
    output logic        illegal
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = instr[15:13];
    assign op     = instr[12:11];

    // Register/immediate fields go straight to the datapath, not through here
    wire unused_fields = ^instr[10:0];

    // Map opcode/op onto the first execution state
    always_comb begin
        next_st  = S_WAIT;
        asel_cls = 1'b0;
        is_cmp   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM) begin
                    next_st = S_WR_IMM;
                end else if (op == OP_MOV_REG) begin
                    next_st  = S_GET_B;
                    asel_cls = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: next_st = S_GET_A;
                    OP_CMP: begin
                        next_st = S_GET_A;
                        is_cmp  = 1'b1;
                    end
                    default: begin  // OP_MVN
                        next_st  = S_GET_B;
                        asel_cls = 1'b1;
                    end
                endcase
            end
            OPC_HALT: next_st = S_HALT;
            default:  illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
            next_st = S_ERR;
`else
            next_st = S_WAIT;
`endif
        end
    end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Moore control FSM for the register-enable datapath. Every output is a
// register loaded from the table for the state being entered, so the
// enables are glitch-free and drop asynchronously on reset.
// Build option: DATAPATH_CTRL_ILLEGAL_TRAP_EN -- illegal opcodes lock the
// FSM in ERR with err=1; otherwise they retire as a one-cycle NOP.
module datapath_ctrl_fsm
    import datapath_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int VSEL_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic               done,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               write,
    output logic [2:0]         nsel,
    output logic [VSEL_W-1:0]  vsel,
    output logic               asel,
    output logic               bsel,
    output logic               err
);

    generate
        if (INSTR_W != 16) begin : g_bad_instr_w
            $error("datapath_ctrl_fsm: only INSTR_W=16 is supported");
        end
    endgenerate

    state_t state, nxt;
    ctrl_t  ctrl, ctrl_n;

    state_t dec_next;
    logic   dec_asel, dec_cmp, dec_illegal;

    datapath_ctrl_decode u_decode (
        .instr    (instr[15:0]),
        .next_st  (dec_next),
        .asel_cls (dec_asel),
        .is_cmp   (dec_cmp),
        .illegal  (dec_illegal)
    );

    // Next-state selection
    always_comb begin
        nxt = state;
        case (state)
            S_WAIT:   if (start) nxt = S_DECODE;
            S_DECODE: nxt = dec_next;
            S_GET_A:  nxt = S_GET_B;
            S_GET_B:  nxt = S_EXEC;
            S_EXEC:   nxt = dec_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: nxt = S_WAIT;
            S_WR_IMM: nxt = S_WAIT;
            S_HALT:   nxt = S_HALT;
            S_ERR:    nxt = S_ERR;
            default:  nxt = S_WAIT;
        endcase
    end

    // Output table for the state about to be entered
    always_comb begin
        ctrl_n = '0;
        case (nxt)
            S_WAIT: ctrl_n.w = 1'b1;
            S_DECODE: begin
`ifndef DATAPATH_CTRL_ILLEGAL_TRAP_EN
                // An illegal word retires from DECODE straight back to WAIT
                ctrl_n.done = dec_illegal;
`endif
            end
            S_GET_A: begin
                ctrl_n.nsel  = NSEL_RN;
                ctrl_n.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl_n.nsel  = NSEL_RM;
                ctrl_n.loadb = 1'b1;
            end
            S_EXEC: begin
                ctrl_n.asel = dec_asel;
                if (dec_cmp) begin
                    ctrl_n.loads = 1'b1;
                    ctrl_n.done  = 1'b1;
                end else begin
                    ctrl_n.loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                ctrl_n.nsel  = NSEL_RD;
                ctrl_n.vsel  = VSEL_C;
                ctrl_n.write = 1'b1;
                ctrl_n.done  = 1'b1;
            end
            S_WR_IMM: begin
                ctrl_n.nsel  = NSEL_RN;
                ctrl_n.vsel  = VSEL_IMM;
                ctrl_n.write = 1'b1;
                ctrl_n.done  = 1'b1;
            end
            // done only on the entry cycle; HALT then sits silent
            S_HALT: ctrl_n.done = (state != S_HALT);
            S_ERR: begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
                ctrl_n.err = 1'b1;
`endif
            end
            default: ctrl_n = '0;
        endcase
    end

    // State and control-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ctrl  <= CTRL_RST;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_n;
        end
    end

    assign w     = ctrl.w;
    assign done  = ctrl.done;
    assign loada = ctrl.loada;
    assign loadb = ctrl.loadb;
    assign loadc = ctrl.loadc;
    assign loads = ctrl.loads;
    assign write = ctrl.write;
    assign nsel  = ctrl.nsel;
    assign vsel  = VSEL_W'(ctrl.vsel);
    assign asel  = ctrl.asel;
    assign bsel  = 1'b0;
    // ERR is unreachable without the trap build, so this register stays 0 there
    assign err   = ctrl.err;

endmodule
